// File: rtl/sysid_pkg.sv
// sysid_pkg: shared types and constants for the system-ID checker.
// Holds the FSM state enum, slave word addresses and default expected values.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    DONE
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEF_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEF_TS = 32'h583F_5A44;

endpackage

// File: rtl/sysid_checker_if.sv
// sysid_checker_if: Avalon-MM read bus between the checker and the sysid slave.
// Ports: avm_address, avm_read (master->slave), avm_readdata (slave->master).
interface sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata
  );

endinterface

// File: rtl/sysid_read_port.sv
// sysid_read_port: issues one fixed-latency read of READ_LATENCY+1 cycles.
// Ports: clock, reset, go/go_addr (start), rdata in; read/address out, cap/data.
import sysid_pkg::*;

module sysid_read_port #(
  parameter int READ_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        go_addr,
  input  logic [31:0] rdata,
  output logic        read,
  output logic        address,
  output logic        cap,
  output logic [31:0] data
);

  localparam logic [2:0] LAST = 3'(READ_LATENCY);

  logic [2:0] cnt;

  // cap marks the final cycle of the window; data is sampled on its edge
  assign cap  = read && (cnt == LAST);
  assign data = rdata;

  // a go arriving with cap chains the next word without a gap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read    <= 1'b0;
      address <= SYSID_ADDR_ID;
      cnt     <= 3'd0;
    end else if (go) begin
      read    <= 1'b1;
      address <= go_addr;
      cnt     <= 3'd0;
    end else if (cap) begin
      read    <= 1'b0;
      address <= SYSID_ADDR_ID;
      cnt     <= 3'd0;
    end else if (read) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid ID and timestamp words and checks them.
// Ports: clock, reset, start, avm (master bus), busy/done, flags, captured words.
import sysid_pkg::*;

module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEF_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEF_TS,
  parameter int          READ_LATENCY       = 0,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  sysid_checker_if.master        avm,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   id_match,
  output logic                   ts_match,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);

  state_t      state, state_n;
  logic        auto_q;
  logic        go, go_addr;
  logic        cap, rd, ra;
  logic [31:0] data;

  sysid_read_port #(
    .READ_LATENCY(READ_LATENCY)
  ) u_port (
    .clock  (clock),
    .reset  (reset),
    .go     (go),
    .go_addr(go_addr),
    .rdata  (avm.avm_readdata),
    .read   (rd),
    .address(ra),
    .cap    (cap),
    .data   (data)
  );

  assign avm.avm_read    = rd;
  assign avm.avm_address = ra;

  assign busy = (state == RD_ID) ||
                (state == RD_TS) ||
                (state == CHECK);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    go      = 1'b0;
    go_addr = SYSID_ADDR_ID;
    unique case (state)
      IDLE: begin
        if (start || auto_q) begin
          state_n = RD_ID;
          go      = 1'b1;
        end
      end
      RD_ID: begin
        if (cap) begin
          state_n = RD_TS;
          go      = 1'b1;
          go_addr = SYSID_ADDR_TS;
        end
      end
      RD_TS: begin
        if (cap) state_n = CHECK;
      end
      CHECK:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // auto_q requests a single run after reset and drops once it is taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      auto_q <= AUTO_START;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE)
        auto_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_value <= 32'h0;
      ts_value <= 32'h0;
      id_match <= 1'b0;
      ts_match <= 1'b0;
      pass     <= 1'b0;
    end else begin
      if (cap && state == RD_ID) id_value <= data;
      if (cap && state == RD_TS) ts_value <= data;
      if (state == CHECK) begin
        id_match <= (id_value == EXPECTED_ID);
        ts_match <= (ts_value == EXPECTED_TIMESTAMP);
        pass     <= (id_value == EXPECTED_ID) &&
                    (ts_value == EXPECTED_TIMESTAMP);
      end
    end
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that sits directly upstream of the system-ID slave in `nios_system`. On a start request, or automatically after reset, it reads the ID word (address 0) and the timestamp word (address 1), then compares both against build-time expected values. It reports pass/fail flags and holds the captured words, so board logic can gate startup or light an LED on a bitstream/software mismatch without the Nios running.

## Interface
Parameters:
- `EXPECTED_ID`, 0: value required at slave address 0.
- `EXPECTED_TIMESTAMP`, 32'h583F_5A44 (1480546884): value required at slave address 1.
- `READ_LATENCY`, 0: cycles from read issue to valid `avm_readdata` (0 = combinational slave); range 0..7.
- `AUTO_START`, 1: when 1, one check runs automatically after reset release.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse or level; sampled only in IDLE.
- `avm_address`  out  1  slave word address (0 = ID, 1 = timestamp).
- `avm_read`  out  1  read strobe.
- `avm_readdata`  in  32  slave read data.
- `busy`  out  1  high from the first read cycle through CHECK.
- `done`  out  1  one-cycle pulse when results update.
- `pass`  out  1  `id_match & ts_match`; held until the next run completes.
- `id_match`  out  1  captured ID equals `EXPECTED_ID`.
- `ts_match`  out  1  captured timestamp equals `EXPECTED_TIMESTAMP`.
- `id_value`  out  32  last captured ID word.
- `ts_value`  out  32  last captured timestamp word.

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- **IDLE**
  - `avm_read` = 0 and `avm_address` = 0.
  - Goes to RD_ID if `start` = 1, or if the auto-start flag is set.
  - The auto-start flag is set by reset when `AUTO_START` = 1 and cleared on leaving IDLE.
- **RD_ID**
  - `avm_read` = 1, `avm_address` = 0 for exactly `READ_LATENCY`+1 cycles; a 3-bit latency counter counts them.
  - On the last cycle's edge, `avm_readdata` is captured into `id_value`; next state RD_TS.
- **RD_TS**
  - Same as RD_ID with `avm_address` = 1; captures into `ts_value`; next state CHECK.
- **CHECK**
  - One cycle. Registers `id_match`, `ts_match` and `pass` from full 32-bit equality; next state DONE.
- **DONE**
  - `done` = 1 for one cycle; next state IDLE.
- `start` asserted in any state other than IDLE is ignored, not queued.
- A `start` held high continuously re-runs the check back-to-back, with one IDLE cycle between runs.
- `avm_read` and `avm_address` are registered outputs and change only on state edges. `avm_address` is stable for the whole read window.
- Reset mid-run aborts immediately. All outputs return to reset values, and the run restarts only via auto-start or `start`.

## Timing
- Reset values:
  - state IDLE.
  - `avm_read`, `avm_address`, `busy`, `done`, `pass`, `id_match`, `ts_match` all 0.
  - `id_value` and `ts_value` 0.
- Latency, with `start` sampled at edge E0 and L = `READ_LATENCY`:
  - RD_ID occupies edges E0..E(L+1).
  - RD_TS occupies edges E(L+1)..E(2L+2).
  - Flags update at edge E(2L+3), with `done` high during the following cycle.
  - Total from start to done: 2L+3 cycles.
- Result flags and captured values change only at the CHECK→DONE edge and the RD capture edges. They are stable otherwise, including across IDLE.

## Structure
- `sysid_pkg` holds:
  - the state enum (IDLE, RD_ID, RD_TS, CHECK, DONE);
  - the address constants `SYSID_ADDR_ID` = 0 and `SYSID_ADDR_TS` = 1;
  - the default expected constants.
- One sub-module, `sysid_read_port`, is natural: it takes an address and a go pulse, issues the read for L+1 cycles, and returns a capture strobe plus data. The FSM instantiates it once and reuses it for both words.

## Test plan
- **Auto-start, correct slave.** Slave model returns 0 at address 0 and 1480546884 at address 1, L=0. Release reset → `done` pulses 3 cycles later; `pass`=1, `id_match`=1, `ts_match`=1, `ts_value`=32'h583F5A44.
- **Timestamp mismatch.** Slave returns 1480546885 at address 1, manual `start` → `ts_match`=0, `id_match`=1, `pass`=0, `ts_value`=32'h583F5A45.
- **Latency sweep.** `READ_LATENCY`=3 with a 3-cycle-delay slave model → `avm_read` high 4 cycles per address, `done` 9 cycles after the start edge, `pass`=1.
- **Start while busy.** Pulse `start` again during RD_TS → exactly one `done` pulse; no second run begins.
- **Reset mid-run.** Assert `reset` during RD_ID → outputs are 0 immediately. With `AUTO_START`=1, a full run completes after release.
- **Held start.** Hold `start` high with the slave ID toggling 0→7 between runs → consecutive `done` pulses 4 cycles apart (L=0); second run shows `id_match`=0, `id_value`=7.
